// File: rtl/tom_dram_pkg.sv
// Shared types and default widths for the tom DRAM pin bridge.
package tom_dram_pkg;

  localparam int ROW_W_DEF       = 11;
  localparam int COL_W_DEF       = 10;
  localparam int ACK_TIMEOUT_DEF = 255;
  localparam int MEM_ADDR_W      = 1 + ROW_W_DEF + COL_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_REFRESH,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/tom_dram_edge.sv
// Registered edge detector for the active-low RAS/CAS strobes; bit order {casl[1:0], rasl[1:0]}.
module tom_dram_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sig_l,
  output logic [3:0] fall,
  output logic [3:0] rise
);

  logic [3:0] prev_q;
  logic [3:0] prev_d;

  assign prev_d = sig_l;

  // Strobes idle high, so the history starts deasserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '1;
    else     prev_q <= prev_d;
  end

  assign fall = prev_q & ~sig_l;
  assign rise = ~prev_q & sig_l;

endmodule

// File: rtl/tom_dram_bridge.sv
// Converts tom DRAM RAS/CAS column accesses into single-word memory controller requests.
// Optional refresh_cnt output is enabled by defining TOM_DRAM_REFRESH_COUNT_EN.
//
// state   | meaning
// IDLE    | no row open, waiting for a RAS fall
// ROW     | row latched, waiting for a qualified CAS fall on the open bank
// REFRESH | CAS-before-RAS refresh, one ram_rdy pulse then wait for RAS release
// ISSUE   | first cycle of mem_req, address/data registered
// WAIT    | mem_req held until mem_ack or watchdog expiry
// HOLD    | ram_rdy (and rd_oe on reads) held until CAS rises
module tom_dram_bridge
  import tom_dram_pkg::*;
#(
  parameter int ROW_W       = ROW_W_DEF,
  parameter int COL_W       = COL_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [1:0]               xrasl,
  input  logic [1:0]               xcasl,
  input  logic [7:0]               xwel,
  input  logic [ROW_W-1:0]         xma,
  input  logic [63:0]              xd_out,
  input  logic                     startcas,
  output logic                     ram_rdy,
  output logic [63:0]              rd_data,
  output logic                     rd_oe,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ROW_W+COL_W:0]     mem_addr,
  output logic [7:0]               mem_be,
  output logic [63:0]              mem_wdata,
  input  logic                     mem_ack,
  input  logic [63:0]              mem_rdata,
`ifdef TOM_DRAM_REFRESH_COUNT_EN
  output logic [15:0]              refresh_cnt,
`endif
  output logic                     timeout_err
);

  localparam int WD_W = $clog2(ACK_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              we_q, we_d;
  logic [7:0]        be_q, be_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              ram_rdy_q, ram_rdy_d;
  logic              rd_oe_q, rd_oe_d;
  logic [63:0]       rd_data_q, rd_data_d;
  logic              tout_q, tout_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              cas_up_q, cas_up_d;
`ifdef TOM_DRAM_REFRESH_COUNT_EN
  logic [15:0]       refresh_cnt_q, refresh_cnt_d;
`endif

  logic [3:0] fall, rise;
  logic [1:0] ras_fall, ras_rise, cas_fall, cas_rise;
  logic       new_bank;

  tom_dram_edge u_edge (
    .clk   (sys_clk),
    .rst   (reset),
    .sig_l ({xcasl, xrasl}),
    .fall  (fall),
    .rise  (rise)
  );

  assign ras_fall = fall[1:0];
  assign ras_rise = rise[1:0];
  assign cas_fall = fall[3:2];
  assign cas_rise = rise[3:2];
  assign new_bank = ~ras_fall[0];

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    row_d     = row_q;
    col_d     = col_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    mem_req_d = mem_req_q;
    ram_rdy_d = ram_rdy_q;
    rd_oe_d   = rd_oe_q;
    rd_data_d = rd_data_q;
    tout_d    = tout_q;
    wdog_d    = wdog_q;
    cas_up_d  = cas_up_q;
`ifdef TOM_DRAM_REFRESH_COUNT_EN
    refresh_cnt_d = refresh_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (|ras_fall) begin
          if (!xcasl[new_bank]) begin
            state_d   = ST_REFRESH;
            ram_rdy_d = 1'b1;
`ifdef TOM_DRAM_REFRESH_COUNT_EN
            refresh_cnt_d = refresh_cnt_q + 16'd1;
`endif
          end else begin
            bank_d  = new_bank;
            row_d   = xma;
            state_d = ST_ROW;
          end
        end
      end

      ST_REFRESH: begin
        ram_rdy_d = 1'b0;
        if (&xrasl) state_d = ST_IDLE;
      end

      ST_ROW: begin
        if (cas_fall[bank_q] && startcas) begin
          col_d     = xma[COL_W-1:0];
          we_d      = ~&xwel;
          be_d      = ~xwel;
          wdata_d   = xd_out;
          mem_req_d = 1'b1;
          wdog_d    = WD_W'(ACK_TIMEOUT);
          cas_up_d  = 1'b0;
          state_d   = ST_ISSUE;
        end else if (ras_rise[bank_q]) begin
          state_d = ST_IDLE;
        end
      end

      // ISSUE accepts a same-cycle ack; a CAS rise seen while waiting is remembered for HOLD.
      ST_ISSUE, ST_WAIT: begin
        if (cas_rise[bank_q]) cas_up_d = 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ram_rdy_d = 1'b1;
          if (!we_q) begin
            rd_data_d = mem_rdata;
            rd_oe_d   = 1'b1;
          end
          state_d = ST_HOLD;
        end else if (wdog_q == WD_W'(1)) begin
          tout_d    = 1'b1;
          mem_req_d = 1'b0;
          ram_rdy_d = 1'b1;
          rd_data_d = '1;
          rd_oe_d   = ~we_q;
          state_d   = ST_HOLD;
        end else begin
          wdog_d  = wdog_q - WD_W'(1);
          state_d = ST_WAIT;
        end
      end

      ST_HOLD: begin
        if (cas_rise[bank_q] || cas_up_q) begin
          ram_rdy_d = 1'b0;
          rd_oe_d   = 1'b0;
          cas_up_d  = 1'b0;
          state_d   = xrasl[bank_q] ? ST_IDLE : ST_ROW;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bank_q    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      mem_req_q <= 1'b0;
      ram_rdy_q <= 1'b0;
      rd_oe_q   <= 1'b0;
      rd_data_q <= '0;
      tout_q    <= 1'b0;
      wdog_q    <= '0;
      cas_up_q  <= 1'b0;
`ifdef TOM_DRAM_REFRESH_COUNT_EN
      refresh_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      mem_req_q <= mem_req_d;
      ram_rdy_q <= ram_rdy_d;
      rd_oe_q   <= rd_oe_d;
      rd_data_q <= rd_data_d;
      tout_q    <= tout_d;
      wdog_q    <= wdog_d;
      cas_up_q  <= cas_up_d;
`ifdef TOM_DRAM_REFRESH_COUNT_EN
      refresh_cnt_q <= refresh_cnt_d;
`endif
    end
  end

  assign ram_rdy     = ram_rdy_q;
  assign rd_data     = rd_data_q;
  assign rd_oe       = rd_oe_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = we_q;
  assign mem_addr    = {bank_q, row_q, col_q};
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign timeout_err = tout_q;
`ifdef TOM_DRAM_REFRESH_COUNT_EN
  assign refresh_cnt = refresh_cnt_q;
`endif

endmodule

// File: tb/tb_tom_dram_bridge.sv
// Directed self-checking bench for tom_dram_bridge (define TOM_DRAM_REFRESH_COUNT_EN to cover refresh_cnt).
module tb_tom_dram_bridge;
  import tom_dram_pkg::*;

  logic                  sys_clk = 1'b0;
  logic                  reset;
  logic [1:0]            xrasl, xcasl;
  logic [7:0]            xwel;
  logic [10:0]           xma;
  logic [63:0]           xd_out;
  logic                  startcas;
  logic                  ram_rdy;
  logic [63:0]           rd_data;
  logic                  rd_oe;
  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [7:0]            mem_be;
  logic [63:0]           mem_wdata;
  logic                  mem_ack;
  logic [63:0]           mem_rdata;
  logic                  timeout_err;
`ifdef TOM_DRAM_REFRESH_COUNT_EN
  logic [15:0]           refresh_cnt;
  logic [15:0]           exp_refresh = 16'd0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  tom_dram_bridge dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .xrasl       (xrasl),
    .xcasl       (xcasl),
    .xwel        (xwel),
    .xma         (xma),
    .xd_out      (xd_out),
    .startcas    (startcas),
    .ram_rdy     (ram_rdy),
    .rd_data     (rd_data),
    .rd_oe       (rd_oe),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
`ifdef TOM_DRAM_REFRESH_COUNT_EN
    .refresh_cnt (refresh_cnt),
`endif
    .timeout_err (timeout_err)
  );

  task automatic tick;
    @(negedge sys_clk);
  endtask

  task automatic open_row(input logic bank, input logic [10:0] row);
    xrasl = bank ? 2'b01 : 2'b10;
    xma   = row;
    tick;
  endtask

  task automatic strobe_col(input logic bank, input logic [9:0] col, input logic [7:0] wel,
                            input logic [63:0] wd);
    xcasl    = bank ? 2'b01 : 2'b10;
    xma      = {1'b0, col};
    xwel     = wel;
    xd_out   = wd;
    startcas = 1'b1;
    tick;
  endtask

  task automatic pulse_ack(input logic [63:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick;
    mem_ack   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if ({mem_req, ram_rdy, rd_oe, mem_we, timeout_err} !== 5'b0)
      begin errors++; $display("FAIL reset_flags got %b expected 00000", {mem_req, ram_rdy, rd_oe, mem_we, timeout_err}); end
    checks++;
    if ({rd_data, mem_wdata, mem_be, mem_addr} !== '0)
      begin errors++; $display("FAIL reset_data got %h/%h/%h/%h expected all 0", rd_data, mem_wdata, mem_be, mem_addr); end
    reset = 1'b0;
    tick;
    checks++;
    if ({mem_req, ram_rdy} !== 2'b00)
      begin errors++; $display("FAIL reset_release got %b expected 00", {mem_req, ram_rdy}); end
  endtask

  task automatic test_read;
    logic ok;
    open_row(1'b0, 11'h123);
    strobe_col(1'b0, 10'h045, 8'hFF, 64'h0);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL read_req got %b expected 1", mem_req); end
    checks++;
    if (mem_addr !== {1'b0, 11'h123, 10'h045})
      begin errors++; $display("FAIL read_addr got %h expected %h", mem_addr, {1'b0, 11'h123, 10'h045}); end
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL read_we got %b expected 0", mem_we); end
    ok = 1'b1;
    repeat (2) begin
      tick;
      if (mem_req !== 1'b1 || ram_rdy !== 1'b0 || mem_addr !== {1'b0, 11'h123, 10'h045}) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL read_req_stable got 0 expected 1"); end
    pulse_ack(64'hDEADBEEF_01234567);
    checks++;
    if (rd_data !== 64'hDEADBEEF_01234567)
      begin errors++; $display("FAIL read_data got %h expected deadbeef01234567", rd_data); end
    checks++;
    if ({ram_rdy, rd_oe, mem_req} !== 3'b110)
      begin errors++; $display("FAIL read_done got %b expected 110", {ram_rdy, rd_oe, mem_req}); end
    ok = 1'b1;
    repeat (4) begin
      tick;
      if (ram_rdy !== 1'b1 || rd_oe !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL read_rdy_held got 0 expected 1"); end
    xcasl = 2'b11; xrasl = 2'b11; startcas = 1'b0;
    tick;
    checks++;
    if ({ram_rdy, rd_oe} !== 2'b00)
      begin errors++; $display("FAIL read_release got %b expected 00", {ram_rdy, rd_oe}); end
    tick;
  endtask

  task automatic test_write;
    open_row(1'b0, 11'h0AA);
    strobe_col(1'b0, 10'h3FF, 8'hF0, 64'h11223344_55667788);
    checks++;
    if ({mem_req, mem_we} !== 2'b11)
      begin errors++; $display("FAIL write_req got %b expected 11", {mem_req, mem_we}); end
    checks++;
    if (mem_be !== 8'h0F) begin errors++; $display("FAIL write_be got %h expected 0f", mem_be); end
    checks++;
    if (mem_wdata !== 64'h11223344_55667788)
      begin errors++; $display("FAIL write_wdata got %h expected 1122334455667788", mem_wdata); end
    checks++;
    if (mem_addr !== {1'b0, 11'h0AA, 10'h3FF})
      begin errors++; $display("FAIL write_addr got %h expected %h", mem_addr, {1'b0, 11'h0AA, 10'h3FF}); end
    checks++;
    if (ram_rdy !== 1'b0) begin errors++; $display("FAIL write_rdy_early got %b expected 0", ram_rdy); end
    pulse_ack(64'h0);
    checks++;
    if ({ram_rdy, rd_oe, mem_req} !== 3'b100)
      begin errors++; $display("FAIL write_done got %b expected 100", {ram_rdy, rd_oe, mem_req}); end
    xcasl = 2'b11; xrasl = 2'b11; startcas = 1'b0; xwel = 8'hFF;
    tick;
    checks++;
    if (ram_rdy !== 1'b0) begin errors++; $display("FAIL write_release got %b expected 0", ram_rdy); end
    tick;
  endtask

  task automatic test_fast_page;
    int nreq;
    nreq = 0;
    open_row(1'b1, 11'h5A5);
    for (int c = 1; c <= 3; c++) begin
      strobe_col(1'b1, 10'(c), 8'hFF, 64'h0);
      if (mem_req === 1'b1) nreq++;
      checks++;
      if (mem_addr !== {1'b1, 11'h5A5, 10'(c)})
        begin errors++; $display("FAIL page_addr col %0d got %h expected %h", c, mem_addr, {1'b1, 11'h5A5, 10'(c)}); end
      tick;
      pulse_ack(64'h100 + 64'(c));
      checks++;
      if (rd_data !== 64'h100 + 64'(c) || ram_rdy !== 1'b1)
        begin errors++; $display("FAIL page_data col %0d got %h/%b expected %h/1", c, rd_data, ram_rdy, 64'h100 + 64'(c)); end
      xcasl = 2'b11;
      tick;
      checks++;
      if (ram_rdy !== 1'b0) begin errors++; $display("FAIL page_release col %0d got %b expected 0", c, ram_rdy); end
    end
    checks++;
    if (nreq != 3) begin errors++; $display("FAIL page_reqs got %0d expected 3", nreq); end
    xrasl = 2'b11; startcas = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_cbr;
    int nrdy, nreq;
    xcasl = 2'b00;
    tick;
    xrasl = 2'b00;
    tick;
    nrdy = (ram_rdy === 1'b1) ? 1 : 0;
    nreq = (mem_req === 1'b1) ? 1 : 0;
    repeat (5) begin
      tick;
      if (ram_rdy === 1'b1) nrdy++;
      if (mem_req === 1'b1) nreq++;
    end
    checks++;
    if (nrdy != 1) begin errors++; $display("FAIL cbr_rdy_pulses got %0d expected 1", nrdy); end
    checks++;
    if (nreq != 0) begin errors++; $display("FAIL cbr_req got %0d expected 0", nreq); end
`ifdef TOM_DRAM_REFRESH_COUNT_EN
    exp_refresh = exp_refresh + 16'd1;
    checks++;
    if (refresh_cnt !== exp_refresh)
      begin errors++; $display("FAIL cbr_count got %0d expected %0d", refresh_cnt, exp_refresh); end
`endif
    xrasl = 2'b11; xcasl = 2'b11;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    int n;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pre got %b expected 0", timeout_err); end
    open_row(1'b0, 11'h001);
    strobe_col(1'b0, 10'h002, 8'hFF, 64'h0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (mem_req !== 1'b1) break;
      n++;
      tick;
    end
    checks++;
    if (n != 255) begin errors++; $display("FAIL timeout_cycles got %0d expected 255", n); end
    checks++;
    if ({timeout_err, ram_rdy, rd_oe} !== 3'b111)
      begin errors++; $display("FAIL timeout_flags got %b expected 111", {timeout_err, ram_rdy, rd_oe}); end
    checks++;
    if (rd_data !== 64'hFFFF_FFFF_FFFF_FFFF)
      begin errors++; $display("FAIL timeout_data got %h expected all ones", rd_data); end
    xcasl = 2'b11; xrasl = 2'b11; startcas = 1'b0;
    tick;
    checks++;
    if ({ram_rdy, timeout_err} !== 2'b01)
      begin errors++; $display("FAIL timeout_release got %b expected 01", {ram_rdy, timeout_err}); end
    tick;
  endtask

  task automatic test_reset_in_wait;
    open_row(1'b0, 11'h07F);
    strobe_col(1'b0, 10'h100, 8'hFF, 64'h0);
    tick;
    tick;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_wait_req got %b expected 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, ram_rdy, timeout_err} !== 3'b000)
      begin errors++; $display("FAIL rst_async got %b expected 000", {mem_req, ram_rdy, timeout_err}); end
    xcasl = 2'b11; xrasl = 2'b11; startcas = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    pulse_ack(64'h5555_AAAA_5555_AAAA);
    checks++;
    if ({ram_rdy, rd_oe} !== 2'b00 || rd_data !== 64'h0)
      begin errors++; $display("FAIL stray_ack got %b/%h expected 00/0", {ram_rdy, rd_oe}, rd_data); end
    open_row(1'b1, 11'h3C3);
    strobe_col(1'b1, 10'h0F0, 8'hFF, 64'h0);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== {1'b1, 11'h3C3, 10'h0F0})
      begin errors++; $display("FAIL post_rst_addr got %b/%h expected 1/%h", mem_req, mem_addr, {1'b1, 11'h3C3, 10'h0F0}); end
    tick;
    xrasl = 2'b11;
    tick;
    pulse_ack(64'hCAFEF00D_12345678);
    checks++;
    if (ram_rdy !== 1'b1 || rd_data !== 64'hCAFEF00D_12345678)
      begin errors++; $display("FAIL ras_rise_wait got %b/%h expected 1/cafef00d12345678", ram_rdy, rd_data); end
    xcasl = 2'b11; startcas = 1'b0;
    tick;
    checks++;
    if (ram_rdy !== 1'b0) begin errors++; $display("FAIL ras_rise_release got %b expected 0", ram_rdy); end
    open_row(1'b0, 11'h010);
    strobe_col(1'b0, 10'h011, 8'hFF, 64'h0);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== {1'b0, 11'h010, 10'h011})
      begin errors++; $display("FAIL after_idle_addr got %b/%h expected 1/%h", mem_req, mem_addr, {1'b0, 11'h010, 10'h011}); end
    pulse_ack(64'h0);
    xcasl = 2'b11; xrasl = 2'b11; startcas = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    reset     = 1'b1;
    xrasl     = 2'b11;
    xcasl     = 2'b11;
    xwel      = 8'hFF;
    xma       = '0;
    xd_out    = '0;
    startcas  = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    test_reset;
    test_read;
    test_write;
    test_fast_page;
    test_cbr;
    test_timeout;
    test_reset_in_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
